// File: rtl/rr_port_scheduler_pkg.sv
// Shared definitions for the round-robin port scheduler.
//   - FSM state encoding (IDLE / BUSY / GAP)
//   - default port count and idle-grant timeout
//   - clog2 helper used to size indices and the hold counter
package rr_port_scheduler_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Ceiling log2, never below 1 so a width derived from it is always legal.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_port_scheduler_pick.sv
// rr_pick: combinational circular priority pick.
//   req_i    : request vector
//   ptr_i    : port with highest priority this round
//   onehot_o : one-hot of the first requester at or after ptr_i (circular)
//   idx_o    : binary index of that requester (0 when none)
//   valid_o  : any requester found
module rr_pick
    import rr_port_scheduler_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IDW   = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDW-1:0]   idx_o,
    output logic             valid_o
);

    int             pos_int;
    logic [IDW-1:0] pos;

    // Walk the ports starting at ptr_i; the first hit wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        pos_int  = 0;
        pos      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos_int = (int'(ptr_i) + i) % N_REQ;
            pos     = IDW'(pos_int);
            if (!valid_o && req_i[pos]) begin
                valid_o       = 1'b1;
                onehot_o[pos] = 1'b1;
                idx_o         = pos;
            end
        end
    end

endmodule

// File: rtl/rr_port_scheduler.sv
// rr_port_scheduler: round-robin arbiter granting a shared output channel
// to one of N_REQ packet sources, holding the grant for a whole packet.
//   clk      : clock
//   reset    : asynchronous active-low reset
//   req      : per-port request, held for the packet duration
//   tail     : per-port last-flit flag
//   xfer     : channel accepted one flit from the granted port
//   grant    : registered one-hot grant
//   grant_id : index of granted port (0 when none)
//   busy     : grant held
//   timeout  : one-cycle pulse after an inactivity revocation
module rr_port_scheduler
    import rr_port_scheduler_pkg::*;
#(
    parameter  int N_REQ    = N_REQ_DEF,
    parameter  int MAX_HOLD = MAX_HOLD_DEF,
    localparam int IDW      = clog2(N_REQ),
    localparam int HW       = clog2(MAX_HOLD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] tail,
    input  logic             xfer,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic             timeout
);

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDW-1:0]   pick_idx;
    logic             pick_valid;

    logic rel_normal, rel_abort, rel_tmo, release_now;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // Release causes in priority order: a completed packet beats an abort,
    // and both beat the inactivity timeout, so timeout only pulses when the
    // port still requests and nothing moved on the final cycle.
    always_comb begin
        rel_normal  = xfer && tail[gid_q];
        rel_abort   = !rel_normal && !req[gid_q];
        rel_tmo     = !rel_normal && !rel_abort && !xfer &&
                      (hold_q == HW'(MAX_HOLD - 1));
        release_now = rel_normal || rel_abort || rel_tmo;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    grant_d = pick_onehot;
                    gid_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_d   = ST_GAP;
                    grant_d   = '0;
                    gid_d     = '0;
                    hold_d    = '0;
                    timeout_d = rel_tmo;
                    ptr_d     = (gid_q == IDW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
                end else if (xfer) begin
                    hold_d = '0;
                end else if (hold_q != HW'(MAX_HOLD - 1)) begin
                    // Guarded so the counter can never wrap inside BUSY.
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gid_q     <= '0;
            grant_q   <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gid_q     <= gid_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = gid_q;
    assign busy     = (state_q == ST_BUSY);
    assign timeout  = timeout_q;

endmodule

// File: doc/rr_port_scheduler.md
RR_PORT_SCHEDULER -- requirements
Module: rr_port_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesting input ports (2..8).
REQ-002 Parameter MAX_HOLD, default 16, SHALL set the idle-grant timeout in clock cycles (2..255).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  per-port request; held high by a port for the duration of its packet.
REQ-006 tail  input  N_REQ  per-port flag; high when that port's current flit is the last of its packet.
REQ-007 xfer  input  1  the shared output channel accepted one flit from the granted port this cycle.
REQ-008 grant  output  N_REQ  one-hot grant, registered.
REQ-009 grant_id  output  clog2(N_REQ)  binary index of the granted port; 0 when none.
REQ-010 busy  output  1  high while a grant is held.
REQ-011 timeout  output  1  one-cycle pulse when a grant is revoked for inactivity.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and GAP.
REQ-013 In IDLE with req nonzero, the block SHALL pick the first requester at or after pointer ptr in circular order and enter BUSY, with grant visible the next cycle (1-cycle latency).
REQ-014 In IDLE with req zero, the block SHALL remain in IDLE with grant = 0.
REQ-015 In BUSY, grant, grant_id and busy SHALL stay constant until release.
REQ-016 Release SHALL occur on: xfer and tail[grant_id] (normal end); req[grant_id] low (abort); or hold counter = MAX_HOLD-1 with no xfer (timeout).
REQ-017 On any release, ptr SHALL become (grant_id+1) mod N_REQ, the state SHALL go to GAP, and grant SHALL be 0 in the following cycle.
REQ-018 GAP SHALL last exactly one cycle and then return to IDLE. A new grant SHALL therefore appear no earlier than 2 cycles after release.
REQ-019 The hold counter SHALL clear on entry to BUSY and on every xfer, and SHALL increment on every other BUSY cycle.
REQ-020 timeout SHALL pulse high for exactly the one cycle following a timeout release.
REQ-021 If xfer, tail and the timeout condition coincide, the block SHALL treat the release as normal, and timeout SHALL stay low.
REQ-022 xfer in IDLE or GAP SHALL be ignored.
REQ-023 ptr SHALL wrap from N_REQ-1 to 0.
REQ-024 grant SHALL never have more than one bit set.

Reset
REQ-025 While reset is low, the block SHALL force: state = IDLE, ptr = 0, hold counter = 0, grant = 0, grant_id = 0, busy = 0, timeout = 0.
REQ-026 A reset asserted mid-packet SHALL drop the grant immediately (asynchronously), and the block SHALL behave as after power-up.
REQ-027 Reset deassertion is assumed synchronized externally, and the first grant SHALL occur no earlier than the first rising edge after deassertion.

Structure
REQ-028 The state encoding, the default N_REQ, the default MAX_HOLD and the clog2 helper SHALL live in the shared router package/macro file.
REQ-029 The circular priority pick SHALL be a separate combinational sub-module rr_pick (inputs req and ptr; outputs one-hot and index).
REQ-030 The hold counter width SHALL be clog2(MAX_HOLD) bits, and the counter SHALL be non-wrapping within BUSY.

Verification
REQ-031 The bench SHALL cover: reset release, then req=0001 -> grant=0001 on cycle 2, busy=1; then xfer with tail[0]=1 -> grant=0 next cycle, ptr=1.
REQ-032 The bench SHALL cover: req=1111 held, every packet being one tail flit -> grants in order 0001, 0010, 0100, 1000, 0001, with a 2-cycle gap between grants.
REQ-033 The bench SHALL cover: grant to port 2, then no xfer for 16 cycles -> timeout pulse on cycle 17, grant=0, and the next grant goes to port 3 if it requests.
REQ-034 The bench SHALL cover: grant to port 1, 3 flits, then req[1] dropped before tail -> release next cycle, timeout=0, ptr=2.
REQ-035 The bench SHALL cover: xfer+tail on the timeout cycle -> normal release with timeout=0.
REQ-036 The bench SHALL cover: reset pulsed low while busy -> grant=0 asynchronously, then after release, req=0100 is granted with ptr having restarted at 0.
